// File: rtl/soc_system_readdata_rxd_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | soc_system_readdata_rxd_if : Avalon-MM s1 + fabric push stream     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface soc_system_readdata_rxd_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        irq;

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    input  in_data, in_valid,
    output readdata, in_ready, irq
  );

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    output in_data, in_valid,
    input  readdata, in_ready, irq
  );
endinterface
`default_nettype wire

// File: rtl/soc_system_readdata_rxd.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | soc_system_readdata_rxd : fabric-to-HPS receive FIFO, Avalon s1    |
// | Optional interrupt + IRQ_MASK register under SOC_RXD_IRQ_EN.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module soc_system_readdata_rxd #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  soc_system_readdata_rxd_if.slave  bus
);

  localparam logic [ADDR_W:0] C_DEPTH    = DEPTH[ADDR_W:0];
  localparam logic [1:0]      C_A_DATA   = 2'd0;
  localparam logic [1:0]      C_A_STATUS = 2'd1;
  localparam logic [1:0]      C_A_MASK   = 2'd2;
  localparam logic [1:0]      C_A_FLUSH  = 2'd3;

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       readdata_q, readdata_d;

  logic        w_rd, w_wr, w_rd_eff;
  logic        w_empty, w_full;
  logic        w_flush, w_push, w_pop;
  logic        w_ovf_set, w_ovf_clr;
  logic [7:0]  w_count8;
  logic [31:0] w_status;
  logic [1:0]  w_mask_rd;

  // Only the low writedata bits carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    w_rd     = bus.chipselect & ~bus.read_n;
    w_wr     = bus.chipselect & ~bus.write_n;
    w_rd_eff = w_rd & ~w_wr;
    w_empty  = (count_q == '0);
    w_full   = (count_q == C_DEPTH);
    w_flush  = w_wr & (bus.address == C_A_FLUSH);
    // A word offered while full is dropped even if a pop happens this cycle.
    w_push   = bus.in_valid & ~w_full & ~w_flush;
    w_pop    = w_rd_eff & (bus.address == C_A_DATA) & ~w_empty;
    w_ovf_set = bus.in_valid & w_full & ~w_flush;
    w_ovf_clr = w_wr & (bus.address == C_A_STATUS) & bus.writedata[2];
    w_count8  = 8'(count_q);
    w_status  = {16'h0000, w_count8, 5'b00000, ovf_q, w_full, w_empty};
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) tail_d = tail_q + 1'b1;
      if (w_pop)  head_d = head_q + 1'b1;
      count_d = count_q + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_pop};
    end
    // Set dominates clear.
    ovf_d = w_ovf_set | (ovf_q & ~w_ovf_clr);
  end

  always_comb begin
    readdata_d = readdata_q;
    if (w_rd_eff) begin
      unique case (bus.address)
        C_A_DATA:   readdata_d = w_empty ? 32'h0 : mem_q[head_q];
        C_A_STATUS: readdata_d = w_status;
        C_A_MASK:   readdata_d = {30'h0, w_mask_rd};
        default:    readdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      readdata_q <= 32'h0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      readdata_q <= readdata_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[tail_q] <= bus.in_data;
  end

`ifdef SOC_RXD_IRQ_EN
  logic [1:0] mask_q, mask_d;
  logic       irq_q, irq_d;

  always_comb begin
    mask_d = mask_q;
    if (w_wr && (bus.address == C_A_MASK)) mask_d = bus.writedata[1:0];
    irq_d = (mask_q[0] & ~w_empty) | (mask_q[1] & ovf_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign w_mask_rd = mask_q;
  assign bus.irq   = irq_q;
`else
  assign w_mask_rd = 2'b00;
  assign bus.irq   = 1'b0;
`endif

  assign bus.readdata = readdata_q;
  assign bus.in_ready = ~w_full;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_readdata_rxd.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_soc_system_readdata_rxd : directed scoreboard bench             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_soc_system_readdata_rxd;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  soc_system_readdata_rxd_if bus();

  soc_system_readdata_rxd #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] sb  [$];   // expected readdata per issued read
  logic [31:0] mdl [$];   // reference FIFO contents

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    sb.push_back(exp);
    tick();
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    chk(tag, bus.readdata, sb.pop_front());
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    mdl.push_back(d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] e;
    e = (mdl.size() != 0) ? mdl.pop_front() : 32'h0;
    rd_reg(2'd0, e, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n        = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    bus.in_data    = 32'h0;
    bus.in_valid   = 1'b0;
    repeat (3) tick();
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("rst_irq", {31'h0, bus.irq}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Basic push / status / ordered pop
    rd_reg(2'd1, 32'h0000_0001, "status_reset");
    push_word(32'hA5A5_0001);
    push_word(32'hA5A5_0002);
    push_word(32'hA5A5_0003);
    rd_reg(2'd1, 32'h0000_0300, "status_3");
    for (int i = 0; i < 4; i++) rd_data("data_basic");
    rd_reg(2'd1, 32'h0000_0001, "status_empty");
    rd_reg(2'd3, 32'h0, "addr3_read");

    // Fill, overflow, clear, drain
    for (int i = 0; i < 16; i++) push_word(32'hB000_0000 + i);
    chk("full_in_ready", {31'h0, bus.in_ready}, 32'h0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    tick();
    bus.in_valid = 1'b0;
    rd_reg(2'd1, 32'h0000_1006, "status_ovf");
    wr_reg(2'd1, 32'h4);
    rd_reg(2'd1, 32'h0000_1002, "status_ovf_clr");
    for (int i = 0; i < 16; i++) rd_data("data_drain");
    chk("drain_in_ready", {31'h0, bus.in_ready}, 32'h1);

    // Simultaneous push and pop across pointer wrap
    push_word(32'hC000_0000);
    for (int i = 1; i <= 40; i++) begin
      bus.in_valid   = 1'b1;
      bus.in_data    = 32'hC000_0000 + i;
      bus.address    = 2'd0;
      bus.chipselect = 1'b1;
      bus.read_n     = 1'b0;
      sb.push_back(mdl.pop_front());
      mdl.push_back(32'hC000_0000 + i);
      tick();
      chk("data_wrap", bus.readdata, sb.pop_front());
    end
    bus.in_valid   = 1'b0;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    rd_reg(2'd1, 32'h0000_0100, "status_wrap");
    rd_data("data_wrap_last");

    // Flush in the same cycle as a push
    for (int i = 0; i < 5; i++) push_word(32'hD000_0000 + i);
    bus.in_valid   = 1'b1;
    bus.in_data    = 32'hD000_00FF;
    bus.address    = 2'd3;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.in_valid   = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    mdl.delete();
    rd_reg(2'd1, 32'h0000_0001, "status_flush");
    rd_data("data_after_flush");

    // Read and write together: the write wins and readdata holds
    push_word(32'hE000_0001);
    rd_reg(2'd1, 32'h0000_0100, "status_pre_conflict");
    bus.address    = 2'd0;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    chk("conflict_hold", bus.readdata, 32'h0000_0100);
    rd_data("data_after_conflict");

`ifdef SOC_RXD_IRQ_EN
    wr_reg(2'd2, 32'h1);
    rd_reg(2'd2, 32'h1, "mask_rd");
    push_word(32'hF000_0001);
    repeat (2) tick();
    chk("irq_nonempty", {31'h0, bus.irq}, 32'h1);
    rd_data("data_irq");
    repeat (2) tick();
    chk("irq_drained", {31'h0, bus.irq}, 32'h0);
    wr_reg(2'd2, 32'h2);
    for (int i = 0; i < 16; i++) push_word(32'hF100_0000 + i);
    repeat (2) tick();
    chk("irq_no_ovf_yet", {31'h0, bus.irq}, 32'h0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    chk("irq_ovf", {31'h0, bus.irq}, 32'h1);
    wr_reg(2'd1, 32'h4);
    repeat (2) tick();
    chk("irq_ovf_clr", {31'h0, bus.irq}, 32'h0);
    wr_reg(2'd3, 32'h0);
    mdl.delete();
    wr_reg(2'd2, 32'h0);
`else
    wr_reg(2'd2, 32'h3);
    rd_reg(2'd2, 32'h0, "mask_absent");
    push_word(32'hF000_0001);
    repeat (2) tick();
    chk("irq_absent", {31'h0, bus.irq}, 32'h0);
    rd_data("data_noirq");
`endif

    // Asynchronous reset while data is queued and a read is pending
    push_word(32'h1234_5678);
    bus.address    = 2'd0;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", bus.readdata, 32'h0);
    chk("async_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    mdl.delete();
    tick();
    reset_n = 1'b1;
    tick();
    rd_reg(2'd1, 32'h0000_0001, "status_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
